// File: rtl/sopc_2_cpu_oci_dct_packer.sv
// Packs 3-bit OCI trace symbols into 30-bit words behind a valid/ready output stage.
// Optional idle auto-flush is enabled by defining SOPC_2_CPU_OCI_DCT_TIMEOUT_EN.
`timescale 1ns/1ps

module sopc_2_cpu_oci_dct_packer #(
  parameter int SYM_W   = 3,
  parameter int SLOTS   = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym_data,
  output logic                     sym_ready,
  input  logic                     flush,
  output logic                     dct_valid,
  input  logic                     dct_ready,
  output logic [SYM_W*SLOTS-1:0]   dct_buffer,
  output logic [3:0]               dct_count,
  output logic [1:0]               dbg_acc_state
);

  // Handshake: a symbol moves on a rising edge where sym_valid & sym_ready,
  // a word moves on a rising edge where dct_valid & dct_ready; the word holds
  // its contents while dct_valid & !dct_ready.

  localparam int         AW      = SYM_W * SLOTS;
  localparam logic [3:0] SLOTS_C = 4'(SLOTS);

  typedef enum logic [1:0] {
    ACC_EMPTY = 2'd0,
    ACC_FILL  = 2'd1,
    ACC_FULL  = 2'd2
  } acc_state_t;

  logic             r_run;
  logic [AW-1:0]    r_acc;
  logic [3:0]       r_acc_cnt;
  acc_state_t       r_acc_state;
  logic [AW-1:0]    r_buf;
  logic [3:0]       r_cnt;
  logic             r_valid;
  logic             r_flush_pend;

  logic             w_out_free;
  logic             w_full;
  logic             w_sym_ready;
  logic             w_accept;
  logic             w_timeout_hit;
  logic             w_flush_req;
  logic [AW-1:0]    w_acc_shift;
  logic [AW-1:0]    w_acc_post;
  logic [3:0]       w_cnt_post;
  logic             w_xfer_full;
  logic             w_xfer_flush;
  logic             w_xfer;
  logic [AW-1:0]    w_acc_d;
  logic [3:0]       w_cnt_d;
  acc_state_t       w_state_d;

  assign w_out_free  = !r_valid || dct_ready;
  assign w_full      = (r_acc_cnt == SLOTS_C);
  assign w_sym_ready = r_run && !(w_full && !w_out_free);
  assign w_accept    = sym_valid && w_sym_ready;
  assign w_flush_req = flush || r_flush_pend || w_timeout_hit;

  // Accumulator contents as if this cycle's symbol were already shifted in.
  assign w_acc_shift = {r_acc[AW-SYM_W-1:0], sym_data};
  assign w_acc_post  = w_accept ? w_acc_shift : r_acc;
  assign w_cnt_post  = r_acc_cnt + {3'b000, w_accept};

  // A full accumulator leaves as-is; a flushed one includes the symbol taken this cycle.
  assign w_xfer_full  = w_full && w_out_free;
  assign w_xfer_flush = !w_full && w_out_free && w_flush_req && (w_cnt_post != 4'd0);
  assign w_xfer       = w_xfer_full || w_xfer_flush;

  always_comb begin
    w_acc_d   = w_acc_post;
    w_cnt_d   = w_cnt_post;
    w_state_d = ACC_FILL;
    if (w_xfer_full) begin
      w_acc_d = w_accept ? {{(AW-SYM_W){1'b0}}, sym_data} : '0;
      w_cnt_d = w_accept ? 4'd1 : 4'd0;
    end else if (w_xfer_flush) begin
      w_acc_d = '0;
      w_cnt_d = 4'd0;
    end
    if (w_cnt_d == 4'd0) begin
      w_state_d = ACC_EMPTY;
    end else if (w_cnt_d == SLOTS_C) begin
      w_state_d = ACC_FULL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run        <= 1'b0;
      r_acc        <= '0;
      r_acc_cnt    <= 4'd0;
      r_acc_state  <= ACC_EMPTY;
      r_buf        <= '0;
      r_cnt        <= 4'd0;
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_acc       <= w_acc_d;
      r_acc_cnt   <= w_cnt_d;
      r_acc_state <= w_state_d;
      if (w_xfer_full) begin
        r_buf   <= r_acc;
        r_cnt   <= r_acc_cnt;
        r_valid <= 1'b1;
      end else if (w_xfer_flush) begin
        r_buf   <= w_acc_post;
        r_cnt   <= w_cnt_post;
        r_valid <= 1'b1;
      end else if (dct_ready) begin
        r_valid <= 1'b0;
      end
      // A flush that cannot be served now waits for the output register.
      if (w_xfer) begin
        r_flush_pend <= 1'b0;
      end else if (w_flush_req && (w_cnt_post != 4'd0)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

`ifdef SOPC_2_CPU_OCI_DCT_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] r_idle;

  assign w_timeout_hit = (r_idle == IW'(TIMEOUT));

  // Counts quiet cycles while a partial word sits in the accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle <= '0;
    end else if (w_accept || w_xfer) begin
      r_idle <= '0;
    end else if ((r_acc_state == ACC_FILL) && !w_timeout_hit) begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  assign w_timeout_hit = (TIMEOUT < 0);
`endif

  assign sym_ready     = w_sym_ready;
  assign dct_valid     = r_valid;
  assign dct_buffer    = r_buf;
  assign dct_count     = r_cnt;
  assign dbg_acc_state = r_acc_state;

endmodule
